// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment type, active-low hex segment table and scanner states
package seven_seg_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef enum logic {GAP, SHOW} state_t;
endpackage

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// hex_to_seg: combinational nibble to active-low {g,f,e,d,c,b,a} pattern
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg_t       o_seg
);
  assign o_seg = SEG_TABLE[i_nib];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexes DIGITS nibbles onto a common-anode display with blank gaps.
// Optional digit blinking is enabled by defining SEVEN_SEG_SCANNER_BLINK_EN.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 16
`ifdef SEVEN_SEG_SCANNER_BLINK_EN
  , parameter int BLINK_DIV  = 250
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [4*DIGITS-1:0]   i_digits,
  input  logic [DIGITS-1:0]     i_dp_in,
`ifdef SEVEN_SEG_SCANNER_BLINK_EN
  input  logic [DIGITS-1:0]     i_blink_mask,
`endif
  output logic [DIGITS-1:0]     o_an,
  output seg_t                  o_seg,
  output logic                  o_dp
);
  localparam int IW   = $clog2(DIGITS);
  localparam int CMAX = PRESCALE > BLANK_CYCLES ? PRESCALE : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic          w_last, w_wrap, w_lit;
  logic [3:0]    w_nib;
  seg_t          w_seg;

  assign w_last = r_cnt == (r_state == SHOW ? SHOW_LAST : GAP_LAST);
  assign w_wrap = r_state == SHOW && w_last && r_idx == IDX_LAST;
  assign w_nib  = i_digits[{r_idx, 2'b00} +: 4];

  hex_to_seg u_dec (.i_nib(w_nib), .o_seg(w_seg));

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= GAP;
    else          r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    if (w_last) w_state_nxt = r_state == GAP ? SHOW : GAP;
  end

`ifdef SEVEN_SEG_SCANNER_BLINK_EN
  localparam int RW = $clog2(BLINK_DIV + 1);
  localparam logic [RW-1:0] RND_LAST = RW'(BLINK_DIV - 1);
  logic          r_phase;
  logic [RW-1:0] r_rnd;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_phase <= 1'b1;
      r_rnd   <= '0;
    end else if (w_wrap) begin
      r_rnd   <= r_rnd == RND_LAST ? '0 : r_rnd + 1'b1;
      r_phase <= r_rnd == RND_LAST ? ~r_phase : r_phase;
    end
  assign w_lit = r_phase | ~i_blink_mask[r_idx];
`else
  assign w_lit = 1'b1;
`endif

  // The output registers double as the capture registers: loaded once per slot, held until the next edge
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      o_an  <= '1;
      o_seg <= SEG_BLANK;
      o_dp  <= 1'b1;
    end else if (w_last) begin
      r_cnt <= '0;
      if (r_state == GAP) begin
        o_an  <= w_lit ? ~(DIGITS'(1) << r_idx) : '1;
        o_seg <= w_lit ? w_seg : SEG_BLANK;
        o_dp  <= ~(w_lit & i_dp_in[r_idx]);
      end else begin
        r_idx <= r_idx == IDX_LAST ? '0 : r_idx + 1'b1;
        o_an  <= '1;
        o_seg <= SEG_BLANK;
        o_dp  <= 1'b1;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: table-driven scan checks through a slot scoreboard plus corner sequences
module tb_seven_seg_scanner;
  typedef struct packed {
    logic [15:0]     dig;
    logic [3:0]      dpi;
    logic [3:0][6:0] s;
  } vec_t;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;

  int   n_cmp = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;
  logic [3:0] prev_an = 4'hF;
  exp_t q[$];
  exp_t m_e;
  exp_t e;
  vec_t tv[19];
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] ea [21] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hF,
                          4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7, 4'hF, 4'hE};
  logic [6:0] es [21] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F,
                          7'h24, 7'h24, 7'h24, 7'h24, 7'h7F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h7F, 7'h00};

  always #5 clk = ~clk;

`ifdef SEVEN_SEG_SCANNER_BLINK_EN
  seven_seg_scanner #(.DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .BLINK_DIV(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_digits(digits), .i_dp_in(dp_in),
    .i_blink_mask(blink_mask), .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp));
`else
  seven_seg_scanner #(.DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_digits(digits), .i_dp_in(dp_in),
    .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp));
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Each new lit slot (an leaves all-ones) is matched against the next scoreboard entry
  always @(negedge clk) begin
    if (mon_en && o_an != 4'hF && prev_an == 4'hF) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_slot: got an=%h expected no slot", o_an);
      end else begin
        m_e = q.pop_front();
        chk("slot_an", {28'd0, o_an}, {28'd0, m_e.an});
        chk("slot_seg", {25'd0, o_seg}, {25'd0, m_e.seg});
        chk("slot_dp", {31'd0, o_dp}, {31'd0, m_e.dp});
      end
    end
    prev_an = o_an;
  end

  task automatic restart(input logic [15:0] d, input logic [3:0] p);
    rst_n = 1'b0;
    @(negedge clk);
    digits = d;
    dp_in = p;
    rst_n = 1'b1;
  endtask

  initial begin
    tv[0] = '{16'h1208, 4'b0000, {7'h79, 7'h24, 7'h40, 7'h00}};
    for (int v = 0; v < 16; v++)
      tv[1 + v] = '{{12'h888, 4'(v)}, 4'b0001, {7'h00, 7'h00, 7'h00, hex_tab[v]}};
    tv[17] = '{16'hABCD, 4'b1010, {7'h08, 7'h03, 7'h46, 7'h21}};
    tv[18] = '{16'hEF57, 4'b0100, {7'h06, 7'h0E, 7'h12, 7'h78}};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_an", {28'd0, o_an}, 32'hF);
    chk("reset_seg", {25'd0, o_seg}, 32'h7F);
    chk("reset_dp", {31'd0, o_dp}, 32'h1);

    restart(16'h1208, 4'b0000);
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      chk($sformatf("seq_an[%0d]", k), {28'd0, o_an}, {28'd0, ea[k]});
      chk($sformatf("seq_seg[%0d]", k), {25'd0, o_seg}, {25'd0, es[k]});
    end

    for (int r = 0; r < 19; r++) begin
      mon_en = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      q.delete();
      for (int i = 0; i < 4; i++) begin
        e.an = 4'hF ^ (4'b0001 << i);
        e.seg = tv[r].s[i];
        e.dp = ~tv[r].dpi[i];
        q.push_back(e);
      end
      digits = tv[r].dig;
      dp_in = tv[r].dpi;
      mon_en = 1'b1;
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk($sformatf("scan_done[%0d]", r), q.size(), 0);
    end
    mon_en = 1'b0;

    restart(16'h1208, 4'b0000);
    @(negedge clk);
    chk("hold_seg_e1", {25'd0, o_seg}, 32'h00);
    digits = 16'h1203;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_seg", {25'd0, o_seg}, 32'h00);
    end
    repeat (17) @(negedge clk);
    chk("recapture_an", {28'd0, o_an}, 32'hE);
    chk("recapture_seg", {25'd0, o_seg}, 32'h30);

    restart(16'h1208, 4'b0000);
    repeat (12) @(negedge clk);
    chk("pre_rst_an", {28'd0, o_an}, 32'hB);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", {28'd0, o_an}, 32'hF);
    chk("mid_rst_seg", {25'd0, o_seg}, 32'h7F);
    chk("mid_rst_dp", {31'd0, o_dp}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_an", {28'd0, o_an}, 32'hE);
    chk("restart_seg", {25'd0, o_seg}, 32'h00);
    repeat (4) @(negedge clk);
    chk("restart_gap", {28'd0, o_an}, 32'hF);
    @(negedge clk);
    chk("restart_d1", {28'd0, o_an}, 32'hD);

`ifdef SEVEN_SEG_SCANNER_BLINK_EN
    blink_mask = 4'b0010;
    restart(16'h1208, 4'b0000);
    for (int r = 0; r < 8; r++) begin
      int n_d1;
      int n_other;
      n_d1 = 0;
      n_other = 0;
      repeat (20) begin
        @(negedge clk);
        if (o_an == 4'hD) n_d1++;
        if (o_an == 4'hE || o_an == 4'hB || o_an == 4'h7) n_other++;
      end
      chk($sformatf("blink_d1[%0d]", r), n_d1, (r % 4) < 2 ? 4 : 0);
      chk($sformatf("blink_other[%0d]", r), n_other, 12);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
